// File: rtl/video_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_timing_gen_if                                             |
// | Purpose  : Bus bundle between the raster timing generator and its users.   |
// |            master = controller side (drives pixel enable, PAL request and  |
// |            timer controls), slave = timing generator (drives raster        |
// |            counters, sync/blank flags, strobes and timer status).          |
// | Signals  : CLK_EN_6MB, PAL_MODE, TIMER_LOAD, TIMER_VAL[31:0], TIMER_EN,    |
// |            TIMER_REPEAT, TIMER_IRQ_ACK  -> generator                       |
// |            H_CNT[8:0], V_CNT[8:0], HBLANK, VBLANK, HSYNC_n, VSYNC_n,       |
// |            LINE_START, FRAME_START, TIMER_IRQ, TIMER_CNT[31:0] <- generator|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface video_timing_gen_if;
   logic        CLK_EN_6MB;
   logic        PAL_MODE;
   logic        TIMER_LOAD;
   logic [31:0] TIMER_VAL;
   logic        TIMER_EN;
   logic        TIMER_REPEAT;
   logic        TIMER_IRQ_ACK;

   logic [8:0]  H_CNT;
   logic [8:0]  V_CNT;
   logic        HBLANK;
   logic        VBLANK;
   logic        HSYNC_n;
   logic        VSYNC_n;
   logic        LINE_START;
   logic        FRAME_START;
   logic        TIMER_IRQ;
   logic [31:0] TIMER_CNT;

   modport master (
      output CLK_EN_6MB, PAL_MODE, TIMER_LOAD, TIMER_VAL, TIMER_EN,
             TIMER_REPEAT, TIMER_IRQ_ACK,
      input  H_CNT, V_CNT, HBLANK, VBLANK, HSYNC_n, VSYNC_n,
             LINE_START, FRAME_START, TIMER_IRQ, TIMER_CNT
   );

   modport slave (
      input  CLK_EN_6MB, PAL_MODE, TIMER_LOAD, TIMER_VAL, TIMER_EN,
             TIMER_REPEAT, TIMER_IRQ_ACK,
      output H_CNT, V_CNT, HBLANK, VBLANK, HSYNC_n, VSYNC_n,
             LINE_START, FRAME_START, TIMER_IRQ, TIMER_CNT
   );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : video_timing_gen                                                |
// | Purpose  : Raster timing generator. Advances H/V counters on each pixel    |
// |            enable, produces registered sync/blank flags, line/frame        |
// |            strobes and a pixel-rate countdown interrupt.                   |
// | Ports    : CLK      - system clock                                         |
// |            nRESETP  - synchronous active-low reset                         |
// |            bus      - video_timing_gen_if.slave (controls in, raster and   |
// |                       timer status out)                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module video_timing_gen #(
   parameter int H_TOTAL      = 384,
   parameter int H_ACTIVE     = 320,
   parameter int HSYNC_START  = 336,
   parameter int HSYNC_LEN    = 32,
   parameter int V_TOTAL_NTSC = 264,
   parameter int V_TOTAL_PAL  = 312,
   parameter int VACT_START   = 16,
   parameter int VACT_END     = 240,
   parameter int VSYNC_NTSC   = 248,
   parameter int VSYNC_PAL    = 272,
   parameter int VSYNC_LEN    = 8
) (
   input  logic              CLK,
   input  logic              nRESETP,
   video_timing_gen_if.slave bus
);

   localparam logic [8:0] c_h_last     = 9'(H_TOTAL - 1);
   localparam logic [8:0] c_h_active   = 9'(H_ACTIVE);
   localparam logic [8:0] c_hs_start   = 9'(HSYNC_START);
   localparam logic [8:0] c_hs_end     = 9'(HSYNC_START + HSYNC_LEN);
   localparam logic [8:0] c_vn_last    = 9'(V_TOTAL_NTSC - 1);
   localparam logic [8:0] c_vp_last    = 9'(V_TOTAL_PAL - 1);
   localparam logic [8:0] c_vact_start = 9'(VACT_START);
   localparam logic [8:0] c_vact_end   = 9'(VACT_END);
   localparam logic [8:0] c_vsn_start  = 9'(VSYNC_NTSC);
   localparam logic [8:0] c_vsn_end    = 9'(VSYNC_NTSC + VSYNC_LEN);
   localparam logic [8:0] c_vsp_start  = 9'(VSYNC_PAL);
   localparam logic [8:0] c_vsp_end    = 9'(VSYNC_PAL + VSYNC_LEN);

   logic [8:0]  h_q, h_d, v_q, v_d;
   logic        pal_q, pal_d;
   logic        hblank_q, hblank_d, vblank_q, vblank_d;
   logic        hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
   logic        line_q, line_d, frame_q, frame_d;
   logic [31:0] tcnt_q, tcnt_d, reload_q, reload_d;
   logic        run_q, run_d, irq_q, irq_d;

   logic        w_h_wrap, w_v_wrap;
   logic [8:0]  w_vs_start, w_vs_end;

   // Raster: flags are derived from the next counter values so that they
   // change on the same edge as the counters they describe.
   always_comb begin
      w_h_wrap = (h_q == c_h_last);
      w_v_wrap = w_h_wrap && (v_q == (pal_q ? c_vp_last : c_vn_last));
      h_d      = h_q;
      v_d      = v_q;
      pal_d    = pal_q;
      if (bus.CLK_EN_6MB) begin
         h_d = w_h_wrap ? 9'd0 : h_q + 9'd1;
         if (w_h_wrap) begin
            v_d = w_v_wrap ? 9'd0 : v_q + 9'd1;
         end
         // Frame standard only switches between frames.
         if (w_v_wrap) begin
            pal_d = bus.PAL_MODE;
         end
      end
      w_vs_start = pal_d ? c_vsp_start : c_vsn_start;
      w_vs_end   = pal_d ? c_vsp_end   : c_vsn_end;
      hblank_d   = (h_d >= c_h_active);
      hsync_n_d  = !((h_d >= c_hs_start) && (h_d < c_hs_end));
      vblank_d   = (v_d < c_vact_start) || (v_d >= c_vact_end);
      vsync_n_d  = !((v_d >= w_vs_start) && (v_d < w_vs_end));
      line_d     = bus.CLK_EN_6MB && w_h_wrap;
      frame_d    = bus.CLK_EN_6MB && w_v_wrap;
   end

   // Countdown timer: load beats count; a zero count expires rather than
   // decrementing, so the period is load value + 1 pixels.
   always_comb begin
      tcnt_d   = tcnt_q;
      reload_d = reload_q;
      run_d    = run_q;
      irq_d    = irq_q && !bus.TIMER_IRQ_ACK;
      if (bus.TIMER_LOAD) begin
         tcnt_d   = bus.TIMER_VAL;
         reload_d = bus.TIMER_VAL;
         run_d    = 1'b1;
      end else if (bus.CLK_EN_6MB && bus.TIMER_EN && run_q) begin
         if (tcnt_q == 32'd0) begin
            irq_d = 1'b1;              // set wins over a coincident ack
            if (bus.TIMER_REPEAT) begin
               tcnt_d = reload_q;
            end else begin
               run_d = 1'b0;
            end
         end else begin
            tcnt_d = tcnt_q - 32'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRESETP) begin
         h_q       <= 9'd0;
         v_q       <= 9'd0;
         pal_q     <= bus.PAL_MODE;
         hblank_q  <= 1'b0;
         vblank_q  <= 1'b1;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         line_q    <= 1'b0;
         frame_q   <= 1'b0;
         tcnt_q    <= 32'd0;
         reload_q  <= 32'd0;
         run_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         pal_q     <= pal_d;
         hblank_q  <= hblank_d;
         vblank_q  <= vblank_d;
         hsync_n_q <= hsync_n_d;
         vsync_n_q <= vsync_n_d;
         line_q    <= line_d;
         frame_q   <= frame_d;
         tcnt_q    <= tcnt_d;
         reload_q  <= reload_d;
         run_q     <= run_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.H_CNT       = h_q;
   assign bus.V_CNT       = v_q;
   assign bus.HBLANK      = hblank_q;
   assign bus.VBLANK      = vblank_q;
   assign bus.HSYNC_n     = hsync_n_q;
   assign bus.VSYNC_n     = vsync_n_q;
   assign bus.LINE_START  = line_q;
   assign bus.FRAME_START = frame_q;
   assign bus.TIMER_IRQ   = irq_q;
   assign bus.TIMER_CNT   = tcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_video_timing_gen                                             |
// | Purpose  : Scoreboard bench. u_full uses the default 384x264/312 timing;   |
// |            u_small uses a scaled raster (24 px, 10/13 lines) so whole      |
// |            NTSC and PAL frames fit in a short run.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_video_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_timing_gen_if tf();
   video_timing_gen_if ts();

   video_timing_gen u_full (.CLK(clk), .nRESETP(rst_n), .bus(tf));

   video_timing_gen #(
      .H_TOTAL(24), .H_ACTIVE(16), .HSYNC_START(18), .HSYNC_LEN(3),
      .V_TOTAL_NTSC(10), .V_TOTAL_PAL(13), .VACT_START(2), .VACT_END(8),
      .VSYNC_NTSC(8), .VSYNC_PAL(10), .VSYNC_LEN(2)
   ) u_small (.CLK(clk), .nRESETP(rst_n), .bus(ts));

   // Selector codes: 0..9 full instance, 10..17 small instance, 20/21 counts.
   localparam int F_H = 0, F_V = 1, F_HB = 2, F_VB = 3, F_HS = 4, F_VS = 5,
                  F_LS = 6, F_FS = 7, F_IRQ = 8, F_TC = 9;
   localparam int S_H = 10, S_V = 11, S_HB = 12, S_VB = 13, S_HS = 14,
                  S_VS = 15, S_LS = 16, S_FS = 17, S_LCNT = 20, S_FCNT = 21;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } item_t;

   item_t sb[$];
   item_t mon_it;
   int    n_cmp = 0;
   int    n_err = 0;
   int    ls_cnt = 0;
   int    fs_cnt = 0;

   function automatic logic [31:0] actual(int sel);
      case (sel)
         F_H:    return {23'd0, tf.H_CNT};
         F_V:    return {23'd0, tf.V_CNT};
         F_HB:   return {31'd0, tf.HBLANK};
         F_VB:   return {31'd0, tf.VBLANK};
         F_HS:   return {31'd0, tf.HSYNC_n};
         F_VS:   return {31'd0, tf.VSYNC_n};
         F_LS:   return {31'd0, tf.LINE_START};
         F_FS:   return {31'd0, tf.FRAME_START};
         F_IRQ:  return {31'd0, tf.TIMER_IRQ};
         F_TC:   return tf.TIMER_CNT;
         S_H:    return {23'd0, ts.H_CNT};
         S_V:    return {23'd0, ts.V_CNT};
         S_HB:   return {31'd0, ts.HBLANK};
         S_VB:   return {31'd0, ts.VBLANK};
         S_HS:   return {31'd0, ts.HSYNC_n};
         S_VS:   return {31'd0, ts.VSYNC_n};
         S_LS:   return {31'd0, ts.LINE_START};
         S_FS:   return {31'd0, ts.FRAME_START};
         S_LCNT: return 32'(ls_cnt);
         S_FCNT: return 32'(fs_cnt);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: counts small-raster strobes, then checks every queued expectation
   // against the outputs presented in this cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ts.LINE_START)  ls_cnt++;
         if (ts.FRAME_START) fs_cnt++;
      end
      while (sb.size() > 0) begin
         mon_it = sb.pop_front();
         n_cmp++;
         if (actual(mon_it.sel) !== mon_it.exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     mon_it.name, actual(mon_it.sel), mon_it.exp, $time);
         end
      end
   end

   task automatic chk(input int sel, input logic [31:0] v, input string nm);
      sb.push_back('{sel, v, nm});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One pixel every 4th clock; outputs must hold over the idle cycles.
   task automatic pix();
      tf.CLK_EN_6MB = 1'b1;
      cyc();
      tf.CLK_EN_6MB = 1'b0;
      cyc();
      cyc();
      cyc();
   endtask

   task automatic chk_full_reset(input string tag);
      chk(F_H, 0, {tag, "_h"});       chk(F_V, 0, {tag, "_v"});
      chk(F_HB, 0, {tag, "_hblank"}); chk(F_VB, 1, {tag, "_vblank"});
      chk(F_HS, 1, {tag, "_hsync"});  chk(F_VS, 1, {tag, "_vsync"});
      chk(F_LS, 0, {tag, "_line"});   chk(F_FS, 0, {tag, "_frame"});
      chk(F_IRQ, 0, {tag, "_irq"});   chk(F_TC, 0, {tag, "_tcnt"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      tf.CLK_EN_6MB = 0; tf.PAL_MODE = 0; tf.TIMER_LOAD = 0; tf.TIMER_VAL = 0;
      tf.TIMER_EN = 0; tf.TIMER_REPEAT = 0; tf.TIMER_IRQ_ACK = 0;
      ts.CLK_EN_6MB = 0; ts.PAL_MODE = 0; ts.TIMER_LOAD = 0; ts.TIMER_VAL = 0;
      ts.TIMER_EN = 0; ts.TIMER_REPEAT = 0; ts.TIMER_IRQ_ACK = 0;

      // Reset state
      rst_n = 1'b0;
      cyc();
      cyc();
      chk_full_reset("rst");
      chk(S_VB, 1, "rst_small_vblank");

      // Release: no strobes
      rst_n = 1'b1;
      cyc();
      chk(F_LS, 0, "rel_line"); chk(F_FS, 0, "rel_frame");
      chk(S_LS, 0, "rel_s_line"); chk(S_FS, 0, "rel_s_frame");

      // Small raster: one NTSC frame (240 px), PAL requested at line 5,
      // then one PAL frame (312 px).
      for (int k = 1; k <= 552; k++) begin
         ts.CLK_EN_6MB = 1'b1;
         cyc();
         case (k)
            15:  chk(S_HB, 0, "s_hblank_15");
            16:  chk(S_HB, 1, "s_hblank_16");
            17:  chk(S_HS, 1, "s_hsync_17");
            18:  chk(S_HS, 0, "s_hsync_18");
            20:  chk(S_HS, 0, "s_hsync_20");
            21:  chk(S_HS, 1, "s_hsync_21");
            24:  begin chk(S_LS, 1, "s_line_24"); chk(S_V, 1, "s_v_24"); end
            25:  chk(S_LS, 0, "s_line_25");
            47:  chk(S_VB, 1, "s_vblank_l1");
            48:  chk(S_VB, 0, "s_vblank_l2");
            120: begin chk(S_V, 5, "s_v_120"); ts.PAL_MODE = 1'b1; end
            192: begin chk(S_VS, 0, "s_ntsc_vsync_l8"); chk(S_VB, 1, "s_vblank_l8"); end
            239: begin chk(S_V, 9, "s_v_239"); chk(S_H, 23, "s_h_239");
                       chk(S_FS, 0, "s_frame_239"); end
            240: begin chk(S_V, 0, "s_v_240"); chk(S_H, 0, "s_h_240");
                       chk(S_FS, 1, "s_frame_240"); chk(S_LCNT, 10, "s_lines_f1");
                       chk(S_FCNT, 1, "s_frames_f1"); end
            241: chk(S_FS, 0, "s_frame_241");
            432: begin chk(S_V, 8, "s_pal_v8"); chk(S_VS, 1, "s_pal_vsync_l8"); end
            480: begin chk(S_V, 10, "s_pal_v10"); chk(S_VS, 0, "s_pal_vsync_l10"); end
            527: chk(S_VS, 0, "s_pal_vsync_l11");
            528: begin chk(S_V, 12, "s_pal_v12"); chk(S_VS, 1, "s_pal_vsync_l12"); end
            551: chk(S_FS, 0, "s_frame_551");
            552: begin chk(S_V, 0, "s_v_552"); chk(S_FS, 1, "s_frame_552");
                       chk(S_LCNT, 23, "s_lines_f2"); chk(S_FCNT, 2, "s_frames_f2"); end
            default: ;
         endcase
      end
      ts.CLK_EN_6MB = 1'b0;

      // Full raster sweep up to line 16 pixel 200; timer loaded at pixel 6144.
      for (int k = 1; k <= 6344; k++) begin
         tf.CLK_EN_6MB = 1'b1;
         if (k == 6144) begin
            tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 1000;
            tf.TIMER_REPEAT = 1'b1; tf.TIMER_EN = 1'b1;
         end
         cyc();
         tf.TIMER_LOAD = 1'b0;
         case (k)
            319:  chk(F_HB, 0, "hblank_319");
            320:  chk(F_HB, 1, "hblank_320");
            335:  chk(F_HS, 1, "hsync_335");
            336:  chk(F_HS, 0, "hsync_336");
            367:  chk(F_HS, 0, "hsync_367");
            368:  chk(F_HS, 1, "hsync_368");
            384:  begin chk(F_H, 0, "h_384"); chk(F_V, 1, "v_384");
                        chk(F_LS, 1, "line_384"); chk(F_FS, 0, "frame_384"); end
            385:  chk(F_LS, 0, "line_385");
            5760: begin chk(F_V, 15, "v_15"); chk(F_VB, 1, "vblank_15"); end
            6144: begin chk(F_V, 16, "v_16"); chk(F_VB, 0, "vblank_16");
                        chk(F_TC, 1000, "tcnt_load1000"); end
            6344: begin chk(F_H, 200, "h_200"); chk(F_TC, 800, "tcnt_800"); end
            default: ;
         endcase
      end

      // Mid-line reset with running timer and a coincident load
      rst_n = 1'b0;
      tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 77;
      cyc();
      chk_full_reset("midrst");
      rst_n = 1'b1; tf.TIMER_LOAD = 1'b0; tf.CLK_EN_6MB = 1'b0;
      cyc();
      chk(F_LS, 0, "midrst_rel_line"); chk(F_FS, 0, "midrst_rel_frame");
      pix();
      chk(F_H, 1, "post_rst_h1");
      chk(F_TC, 0, "post_rst_timer_stopped"); chk(F_IRQ, 0, "post_rst_irq");

      // Repeat timer, value 9: expiry every 10 pixels
      tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 9; tf.TIMER_REPEAT = 1'b1; tf.TIMER_EN = 1'b1;
      cyc();
      tf.TIMER_LOAD = 1'b0;
      chk(F_TC, 9, "rep_load9"); chk(F_IRQ, 0, "rep_load_irq");
      for (int p = 1; p <= 10; p++) begin
         pix();
         if (p == 5)  chk(F_TC, 4, "rep_p5");
         if (p == 9)  begin chk(F_TC, 0, "rep_p9_cnt"); chk(F_IRQ, 0, "rep_p9_irq"); end
         if (p == 10) begin chk(F_TC, 9, "rep_p10_reload"); chk(F_IRQ, 1, "rep_p10_irq"); end
      end
      tf.TIMER_IRQ_ACK = 1'b1;
      cyc();
      tf.TIMER_IRQ_ACK = 1'b0;
      chk(F_IRQ, 0, "rep_ack");
      tf.TIMER_EN = 1'b0;
      pix(); pix(); pix();
      chk(F_TC, 9, "freeze_cnt");
      tf.TIMER_EN = 1'b1;
      for (int p = 11; p <= 19; p++) pix();
      chk(F_TC, 0, "rep_p19_cnt"); chk(F_IRQ, 0, "rep_p19_irq");
      tf.TIMER_IRQ_ACK = 1'b1; tf.CLK_EN_6MB = 1'b1;
      cyc();
      tf.TIMER_IRQ_ACK = 1'b0; tf.CLK_EN_6MB = 1'b0;
      chk(F_IRQ, 1, "ack_vs_expiry_irq"); chk(F_TC, 9, "ack_vs_expiry_cnt");

      // One-shot, value 3
      tf.TIMER_IRQ_ACK = 1'b1; tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 3; tf.TIMER_REPEAT = 1'b0;
      cyc();
      tf.TIMER_IRQ_ACK = 1'b0; tf.TIMER_LOAD = 1'b0;
      chk(F_TC, 3, "os_load3"); chk(F_IRQ, 0, "os_load_irq");
      pix(); pix(); pix();
      chk(F_TC, 0, "os_p3_cnt"); chk(F_IRQ, 0, "os_p3_irq");
      pix();
      chk(F_IRQ, 1, "os_p4_irq"); chk(F_TC, 0, "os_p4_cnt");
      tf.TIMER_IRQ_ACK = 1'b1;
      cyc();
      tf.TIMER_IRQ_ACK = 1'b0;
      pix(); pix(); pix(); pix();
      chk(F_IRQ, 0, "os_no_reirq"); chk(F_TC, 0, "os_hold0");

      // Load coinciding with expiry
      tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 3;
      cyc();
      tf.TIMER_LOAD = 1'b0;
      pix(); pix(); pix();
      chk(F_TC, 0, "lx_pre_cnt");
      tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 20; tf.CLK_EN_6MB = 1'b1;
      cyc();
      tf.TIMER_LOAD = 1'b0; tf.CLK_EN_6MB = 1'b0;
      chk(F_IRQ, 0, "lx_irq"); chk(F_TC, 20, "lx_cnt20");
      pix();
      chk(F_TC, 19, "lx_cnt19");

      // Load 0 with repeat: expires on every pixel
      tf.TIMER_LOAD = 1'b1; tf.TIMER_VAL = 0; tf.TIMER_REPEAT = 1'b1;
      cyc();
      tf.TIMER_LOAD = 1'b0;
      pix();
      chk(F_IRQ, 1, "z_p1_irq"); chk(F_TC, 0, "z_p1_cnt");
      tf.TIMER_IRQ_ACK = 1'b1;
      cyc();
      tf.TIMER_IRQ_ACK = 1'b0;
      chk(F_IRQ, 0, "z_ack");
      pix();
      chk(F_IRQ, 1, "z_p2_irq");

      cyc();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator sitting directly downstream of the clock divider. It consumes the single-cycle `CLK_EN_6MB` pixel enable and produces horizontal/vertical counters, sync and blank flags, line/frame strobes and a programmable pixel-rate countdown interrupt. Everything runs on the system clock `CLK`, and every state change is gated by `CLK_EN_6MB`. Sprite, fix-layer and video-output stages all derive their raster position from this block.

## Interface
- `H_TOTAL`, 384: pixels per line. `H_CNT` runs 0..H_TOTAL-1.
- `H_ACTIVE`, 320: `HBLANK` is high when `H_CNT >= H_ACTIVE`.
- `HSYNC_START`, 336: first pixel of the horizontal sync pulse.
- `HSYNC_LEN`, 32: horizontal sync width in pixels.
- `V_TOTAL_NTSC`, 264: lines per frame when PAL is not selected.
- `V_TOTAL_PAL`, 312: lines per frame when PAL is selected.
- `VACT_START`, 16: first active line.
- `VACT_END`, 240: first line after the active area. `VBLANK` is high when `V_CNT < VACT_START` or `V_CNT >= VACT_END`.
- `VSYNC_NTSC`, 248: first vertical sync line in NTSC.
- `VSYNC_PAL`, 272: first vertical sync line in PAL.
- `VSYNC_LEN`, 8: vertical sync height in lines.
- `CLK` in 1: system clock.
- `nRESETP` in 1: active-low reset, synchronous to `CLK`. This is fixed.
- `CLK_EN_6MB` in 1: pixel enable, high for one `CLK` cycle per pixel.
- `PAL_MODE` in 1: frame standard request.
- `TIMER_LOAD` in 1: one-cycle strobe that loads the countdown with `TIMER_VAL`.
- `TIMER_VAL` in 32: countdown load value. It is also latched as the reload value.
- `TIMER_EN` in 1: countdown runs while high.
- `TIMER_REPEAT` in 1: on expiry, 1 reloads the countdown and 0 stops it.
- `TIMER_IRQ_ACK` in 1: clears `TIMER_IRQ`.
- `H_CNT` out 9: current pixel.
- `V_CNT` out 9: current line.
- `HBLANK` out 1, `VBLANK` out 1: blanking flags.
- `HSYNC_n` out 1, `VSYNC_n` out 1: active-low syncs.
- `LINE_START` out 1: one-cycle strobe.
- `FRAME_START` out 1: one-cycle strobe.
- `TIMER_IRQ` out 1: sticky interrupt level.
- `TIMER_CNT` out 32: live countdown value.

## Operation
- Reset values when `nRESETP` is sampled low:
  - `H_CNT` = 0, `V_CNT` = 0.
  - `HBLANK` = 0, `VBLANK` = 1.
  - `HSYNC_n` = 1, `VSYNC_n` = 1.
  - `LINE_START` = 0, `FRAME_START` = 0.
  - `TIMER_CNT` = 0, reload register = 0, running flag = 0, `TIMER_IRQ` = 0.
  - Internal `pal_r` takes the value of `PAL_MODE`.
- Reset overrides every other input in the same cycle. A timer load issued during reset is lost.
- Raster counters, per `CLK_EN_6MB`:
  - `H_CNT` increments. At H_TOTAL-1 it wraps to 0 and `V_CNT` increments.
  - `V_CNT` wraps to 0 after V_TOTAL-1, where V_TOTAL is selected by `pal_r`.
- `pal_r` re-samples `PAL_MODE` only on the `V_CNT` wrap edge. A `PAL_MODE` change takes effect from the next frame and never shortens or stretches the current one.
- Flags are registered and updated on the same edge as the counters, so they always match the displayed counter values. There is no extra latency.
  - `HSYNC_n` is low for `HSYNC_START <= H_CNT < HSYNC_START+HSYNC_LEN`.
  - `VSYNC_n` is low for `VS <= V_CNT < VS+VSYNC_LEN`, where VS comes from `pal_r`.
- Strobes:
  - `LINE_START` is high for exactly one `CLK` cycle, the cycle after the edge where `H_CNT` becomes 0.
  - `FRAME_START` behaves the same, for the edge where both `H_CNT` and `V_CNT` become 0.
  - Neither strobe asserts on reset release.
- Timer, one action per `CLK` with priority reset > load > count:
  - Load: on `TIMER_LOAD`, `TIMER_CNT` and the reload register take `TIMER_VAL` and the running flag is set.
  - Count: on `CLK_EN_6MB` with `TIMER_EN` high and the running flag set, a count of 0 means expiry. Otherwise `TIMER_CNT` decrements.
  - Expiry sets `TIMER_IRQ`. With `TIMER_REPEAT` high, `TIMER_CNT` takes the reload value. With `TIMER_REPEAT` low, the running flag clears and `TIMER_CNT` stays 0.
  - The expiry period is therefore the load value + 1 pixels.
- Boundary rules:
  - A load coinciding with expiry: the load wins and no IRQ is raised.
  - A load of 0 with `TIMER_REPEAT` high expires on every pixel.
  - `TIMER_EN` low freezes the count without losing it.
  - `TIMER_IRQ` stays set until `TIMER_IRQ_ACK`. If ack and expiry coincide, the set wins.
  - No 32-bit underflow is possible, because a count of 0 always expires instead of decrementing.

## Timing
- Single clock domain. All outputs are registered and there are no combinational input-to-output paths.
- Counter and flag latency is 0 cycles from the enable edge.
- Strobes and `TIMER_IRQ` assert on the same edge as the counter change that causes them.
- Frame length:
  - NTSC: 384×264 = 101376 pixel enables.
  - PAL: 384×312 = 119808 pixel enables.
- Outputs hold constant between enables, regardless of the enable spacing.

## Test plan
- Reset release, then 101376 enables with `PAL_MODE`=0 → `FRAME_START` fires once, exactly one cycle after the 101376th enable; `LINE_START` count = 264; `H_CNT`/`V_CNT` are back at 0.
- Toggle `PAL_MODE` to 1 mid-frame at `V_CNT`=100 → current frame is still 264 lines; the next frame is 312 lines with `VSYNC_n` low on lines 272–279.
- Sweep one line → `HBLANK` rises at `H_CNT`=320; `HSYNC_n` is low for `H_CNT` 336–367 and high at 368; `VBLANK` is high at `V_CNT`=15 and low at 16.
- Load `TIMER_VAL`=9 with repeat, enable every 4th `CLK` → IRQ every 10 pixels (40 `CLK`); ack clears it; an ack coincident with expiry leaves IRQ set.
- Load with `TIMER_REPEAT`=0, value 3 → one IRQ after 4 pixels, then `TIMER_CNT` holds at 0 with no further IRQ; a load asserted on the expiry cycle → no IRQ and the new value is loaded.
- Assert `nRESETP` low mid-line at `H_CNT`=200 while the timer is running → on the next edge all outputs take their reset values; `TIMER_LOAD` in the same cycle is ignored.
